// File: rtl/invaders_pkg.sv
// rtl/invaders_pkg.sv - shared types and screen/sprite constants for the game peripheral
package invaders_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLY      = 2'd1,
    COOLDOWN = 2'd2
  } msl_state_t;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int PLAYER_W = 30;
  localparam int PLAYER_H = 20;

endpackage

// File: rtl/missile_seq.sv
// rtl/missile_seq.sv - single-missile launch/flight/cooldown sequencer, frame-paced
module missile_seq
  import invaders_pkg::*;
#(
  parameter int PLAYER_ROW  = 430,
  parameter int MSL_STEP    = 8,
  parameter int COOL_FRAMES = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_frame_tick,
  input  logic        i_fire,
  input  logic        i_hit,
  input  logic [11:0] i_col,
  output logic        o_active,
  output logic [11:0] o_row,
  output logic [11:0] o_col
);

  localparam logic [11:0] L_ROW0      = 12'(PLAYER_ROW);
  localparam logic [11:0] L_MSL_STEP  = 12'(MSL_STEP);
  localparam logic [11:0] L_COL_OFF   = 12'(PLAYER_W / 2);
  localparam logic [7:0]  L_COOL_LAST = 8'(COOL_FRAMES - 1);

  msl_state_t  r_state, w_state_next;
  logic        r_fire_q, r_fire_pend, r_hit_pend;
  logic [7:0]  r_cool_cnt, w_cool_next;
  logic [11:0] r_row, w_row_next, r_col, w_col_next;
  logic        r_active, w_active_next;
  logic        w_fire_edge, w_fire_now, w_hit_now;

  // An edge or hit arriving on the tick cycle itself still counts for that tick.
  assign w_fire_edge = i_fire & ~r_fire_q;
  assign w_fire_now  = r_fire_pend | w_fire_edge;
  assign w_hit_now   = r_hit_pend | i_hit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fire_q    <= 1'b0;
      r_fire_pend <= 1'b0;
      r_hit_pend  <= 1'b0;
    end else begin
      r_fire_q <= i_fire;
      if (i_frame_tick) begin
        r_fire_pend <= 1'b0;
        r_hit_pend  <= 1'b0;
      end else begin
        if (w_fire_edge) r_fire_pend <= 1'b1;
        if (i_hit)       r_hit_pend  <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_cool_cnt <= 8'd0;
      r_row      <= L_ROW0;
      r_col      <= 12'd0;
      r_active   <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_cool_cnt <= w_cool_next;
      r_row      <= w_row_next;
      r_col      <= w_col_next;
      r_active   <= w_active_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_cool_next   = r_cool_cnt;
    w_row_next    = r_row;
    w_col_next    = r_col;
    w_active_next = r_active;
    if (i_frame_tick) begin
      case (r_state)
        IDLE: begin
          if (w_fire_now) begin
            w_state_next  = FLY;
            w_row_next    = L_ROW0;
            w_col_next    = i_col + L_COL_OFF;
            w_active_next = 1'b1;
          end
        end
        FLY: begin
          // Compare before subtracting so the row can never wrap past the top.
          if (w_hit_now || (r_row <= L_MSL_STEP)) begin
            w_state_next  = COOLDOWN;
            w_active_next = 1'b0;
            w_cool_next   = L_COOL_LAST;
          end else begin
            w_row_next = r_row - L_MSL_STEP;
          end
        end
        COOLDOWN: begin
          if (r_cool_cnt == 8'd0) w_state_next = IDLE;
          else                    w_cool_next  = r_cool_cnt - 8'd1;
        end
        default: w_state_next = IDLE;
      endcase
    end
  end

  assign o_active = r_active;
  assign o_row    = r_row;
  assign o_col    = r_col;

endmodule

// File: rtl/player_ctrl.sv
// rtl/player_ctrl.sv - frame-paced player column with edge clamps, plus missile sequencer
module player_ctrl
  import invaders_pkg::*;
#(
  parameter int COL_INIT    = 305,
  parameter int COL_MIN     = 0,
  parameter int COL_MAX     = H_ACTIVE - PLAYER_W - 1,
  parameter int STEP        = 4,
  parameter int PLAYER_ROW  = 430,
  parameter int MSL_STEP    = 8,
  parameter int COOL_FRAMES = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_fire,
  input  logic        hit,
  output logic [11:0] btn_col,
  output logic        msl_active,
  output logic [11:0] msl_row,
  output logic [11:0] msl_col
);

  localparam logic [11:0] L_INIT = 12'(COL_INIT);
  localparam logic [11:0] L_MIN  = 12'(COL_MIN);
  localparam logic [11:0] L_MAX  = 12'(COL_MAX);
  localparam logic [11:0] L_STEP = 12'(STEP);

  logic [11:0] r_col, w_col_next;

  always_comb begin
    w_col_next = r_col;
    if (btn_left && !btn_right)
      w_col_next = (r_col < L_MIN + L_STEP) ? L_MIN : r_col - L_STEP;
    else if (btn_right && !btn_left)
      w_col_next = (r_col > L_MAX - L_STEP) ? L_MAX : r_col + L_STEP;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)            r_col <= L_INIT;
    else if (frame_tick) r_col <= w_col_next;
  end

  assign btn_col = r_col;

  // Launch column uses the pre-move column, since r_col updates on the same edge.
  missile_seq #(
    .PLAYER_ROW  (PLAYER_ROW),
    .MSL_STEP    (MSL_STEP),
    .COOL_FRAMES (COOL_FRAMES)
  ) u_missile_seq (
    .clk          (clk),
    .rst          (rst),
    .i_frame_tick (frame_tick),
    .i_fire       (btn_fire),
    .i_hit        (hit),
    .i_col        (r_col),
    .o_active     (msl_active),
    .o_row        (msl_row),
    .o_col        (msl_col)
  );

endmodule

// File: tb/tb_player_ctrl.sv
// tb/tb_player_ctrl.sv - randomized and directed bench for player_ctrl against a frame-level model
module tb_player_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_tick, btn_left, btn_right, btn_fire, hit;
  logic [11:0] btn_col, msl_row, msl_col;
  logic        msl_active;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: plain integers, phases and frames-remaining counters.
  int m_col, m_row, m_mcol, m_phase, m_cool_left;
  bit m_active, m_fire_pend, m_hit_pend, m_fire_prev;

  always #5 clk = ~clk;

  player_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .btn_left   (btn_left),
    .btn_right  (btn_right),
    .btn_fire   (btn_fire),
    .hit        (hit),
    .btn_col    (btn_col),
    .msl_active (msl_active),
    .msl_row    (msl_row),
    .msl_col    (msl_col)
  );

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_col = 305; m_row = 430; m_mcol = 0; m_phase = 0; m_cool_left = 0;
    m_active = 0; m_fire_pend = 0; m_hit_pend = 0; m_fire_prev = 0;
  endtask

  task automatic model_step(input bit tk, input bit l, input bit r, input bit f, input bit h);
    bit edge_f, fire_now, hit_now;
    int old_col;
    edge_f   = f && !m_fire_prev;
    fire_now = m_fire_pend || edge_f;
    hit_now  = m_hit_pend || h;
    if (tk) begin
      old_col = m_col;
      if (l && !r)      m_col = (m_col - 4 < 0) ? 0 : m_col - 4;
      else if (r && !l) m_col = (m_col + 4 > 609) ? 609 : m_col + 4;
      if (m_phase == 0) begin
        if (fire_now) begin
          m_phase = 1; m_row = 430; m_mcol = old_col + 15; m_active = 1;
        end
      end else if (m_phase == 1) begin
        if (hit_now || m_row - 8 <= 0) begin
          m_phase = 2; m_active = 0; m_cool_left = 15;
        end else begin
          m_row = m_row - 8;
        end
      end else begin
        m_cool_left = m_cool_left - 1;
        if (m_cool_left == 0) m_phase = 0;
      end
      m_fire_pend = 0;
      m_hit_pend  = 0;
    end else begin
      if (edge_f) m_fire_pend = 1;
      if (h)      m_hit_pend  = 1;
    end
    m_fire_prev = f;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".col"},    btn_col,             12'(m_col));
    check({tag, ".active"}, {11'd0, msl_active}, {11'd0, m_active});
    check({tag, ".row"},    msl_row,             12'(m_row));
    check({tag, ".mcol"},   msl_col,             12'(m_mcol));
  endtask

  task automatic cyc(input bit tk, input bit l, input bit r, input bit f, input bit h, input string tag);
    @(negedge clk);
    frame_tick = tk; btn_left = l; btn_right = r; btn_fire = f; hit = h;
    model_step(tk, l, r, f, h);
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic frame(input bit l, input bit r, input bit f, input bit h, input string tag);
    for (int i = 0; i < 4; i++) cyc(i == 3, l, r, f, h && (i == 1), tag);
  endtask

  task automatic quiet_inputs();
    frame_tick = 0; btn_left = 0; btn_right = 0; btn_fire = 0; hit = 0;
  endtask

  initial begin
    int n;
    rst = 1'b0;
    quiet_inputs();
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 3; i++) frame(0, 1, 0, 0, "right");
    check("right3_col", btn_col, 12'd317);
    check("right3_inactive", {11'd0, msl_active}, 12'd0);

    for (int i = 0; i < 90; i++) frame(1, 0, 0, 0, "left_clamp");
    check("left_clamp_col", btn_col, 12'd0);
    for (int i = 0; i < 165; i++) frame(0, 1, 0, 0, "right_clamp");
    check("right_clamp_col", btn_col, 12'd609);
    for (int i = 0; i < 76; i++) frame(1, 0, 0, 0, "back");
    check("back_col", btn_col, 12'd305);

    frame(0, 0, 1, 0, "launch");
    check("launch_active", {11'd0, msl_active}, 12'd1);
    check("launch_row", msl_row, 12'd430);
    check("launch_col", msl_col, 12'd320);
    frame(0, 0, 1, 0, "hold");
    check("hold_row", msl_row, 12'd422);
    for (int i = 0; i < 3; i++) frame(0, 1, 1, 0, "hold_move");

    n = 0;
    while (m_row != 230 && n < 100) begin
      frame(0, 0, 0, 0, "fly");
      n++;
    end
    check("fly_to_230", msl_row, 12'd230);
    frame(0, 0, 0, 1, "hit");
    check("hit_inactive", {11'd0, msl_active}, 12'd0);
    for (int i = 0; i < 15; i++) frame(0, 0, (i % 2) == 0, 0, "cool_fire");
    check("cool_discard", {11'd0, msl_active}, 12'd0);
    frame(0, 0, 0, 0, "rearm");
    frame(0, 0, 1, 0, "relaunch");
    check("relaunch_active", {11'd0, msl_active}, 12'd1);

    n = 0;
    while (m_phase == 1 && n < 100) begin
      frame(0, 0, 0, 0, "top");
      n++;
    end
    check("top_row", msl_row, 12'd6);
    check("top_inactive", {11'd0, msl_active}, 12'd0);

    for (int i = 0; i < 3; i++) frame(1, 1, 0, 0, "both");

    for (int i = 0; i < 3000; i++)
      cyc(($urandom % 6) == 0, 1'($urandom), 1'($urandom), ($urandom % 3) == 0,
          ($urandom % 16) == 0, "rand");

    n = 0;
    while (m_phase != 0 && n < 40) begin
      frame(0, 0, 0, 0, "drain");
      n++;
    end
    frame(0, 0, 0, 0, "pre");
    frame(0, 0, 1, 0, "rst_launch");
    for (int i = 0; i < 3; i++) frame(0, 0, 1, 0, "rst_fly");
    check("rst_pre_active", {11'd0, msl_active}, 12'd1);
    @(negedge clk);
    #2;
    rst = 1'b0;
    quiet_inputs();
    model_reset();
    #1;
    check_all("async_rst");
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) frame(0, 0, 0, 0, "post_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/player_ctrl.md
# player_ctrl

Sequencing controller for the player sprite and its missile in the VGA game peripheral. It converts synchronized left/right/fire button levels into a frame-paced player column, and drives the `btn_col` input of the player sprite module. It also runs a single-missile launch/flight/cooldown state machine whose row/column outputs feed the missile renderer and collision logic. All state changes happen only on the frame tick, so sprite positions never change mid-frame.

## Interface
- `COL_INIT`, 305: player column after reset. The sprite occupies columns col+1..col+30.
- `COL_MIN`, 0: lowest allowed player column.
- `COL_MAX`, 609: highest allowed player column (609+30 = 639).
- `STEP`, 4: pixels moved per frame tick.
- `PLAYER_ROW`, 430: missile launch row (player top row).
- `MSL_STEP`, 8: rows the missile rises per frame tick.
- `COOL_FRAMES`, 15: frame ticks spent in COOLDOWN before re-arming.

Ports:
- `clk` in 1: pixel clock (31.5 MHz).
- `rst` in 1: asynchronous, active-low reset.
- `frame_tick` in 1: one-cycle pulse at the start of vertical blank.
- `btn_left` in 1: synchronized, debounced level.
- `btn_right` in 1: synchronized, debounced level.
- `btn_fire` in 1: synchronized, debounced level.
- `hit` in 1: one-cycle pulse from collision logic; the missile struck a target.
- `btn_col` out 12: player column, goes to the player sprite module.
- `msl_active` out 1: missile visible and in flight.
- `msl_row` out 12: missile top row.
- `msl_col` out 12: missile column.

## Operation
- **Movement.** On `frame_tick`, if exactly one of `btn_left` / `btn_right` is high, `btn_col` moves by STEP in that direction. Both high or both low: no move.
- **Clamp.**
  - Left: if `btn_col < COL_MIN + STEP`, set `btn_col = COL_MIN`.
  - Right: if `btn_col > COL_MAX - STEP`, set `btn_col = COL_MAX`.
  - No wrap-around and no underflow in either direction.
- **Fire capture.** `btn_fire` is registered every cycle.
  - A rising edge (0→1) sets `fire_pend`. Holding the button launches exactly one missile.
  - `fire_pend` is consumed at the next `frame_tick`.
  - If the FSM is not in IDLE at that tick, the pending fire is discarded.
- **Hit capture.** A `hit` pulse sets `hit_pend`, which is consumed at the next `frame_tick`. It is ignored unless the FSM is in FLY.
- **Missile FSM.** All transitions occur on `frame_tick` only.
  - IDLE → FLY when `fire_pend`. Load `msl_row = PLAYER_ROW` and `msl_col = btn_col + 15` (centre of sprite, value before this tick's move). Set `msl_active = 1`.
  - FLY → COOLDOWN when `hit_pend`, or when `msl_row <= MSL_STEP` (top reached). Clear `msl_active` and load `cool_cnt = COOL_FRAMES - 1`.
  - FLY otherwise: `msl_row -= MSL_STEP`. `msl_col` stays constant; the missile does not follow the player.
  - COOLDOWN: decrement `cool_cnt`. When `cool_cnt == 0`, go to IDLE.
- **Simultaneous events.**
  - A `hit` and a `frame_tick` in the same cycle count as a hit for that tick.
  - A fire edge and a `frame_tick` in the same cycle count as pending for that tick.
  - Movement and missile updates happen in the same tick, independently.
- **Arithmetic.** All row/column arithmetic is 12-bit unsigned with explicit clamp or compare before any subtraction.

## Timing
- **Reset values:** `btn_col = COL_INIT`, `msl_active = 0`, `msl_row = PLAYER_ROW`, `msl_col = 0`, state IDLE, `fire_pend = 0`, `hit_pend = 0`, `cool_cnt = 0`.
- **Latency:** all outputs are registered. They take their new value on the cycle after the `frame_tick` cycle and hold stable until the next tick.
- **Fire-to-launch:** a fire edge becomes visible 1 cycle after the first `frame_tick` at or after the edge. Worst case is one frame of latency.
- **Reset mid-flight:** asserting `rst` immediately returns every register to its reset value. Any missile in flight is lost, and no pending fire survives.
- **Missile lifetime:** with defaults, 430/8 gives 54 flight frames, then 15 cooldown frames.

## Structure
- Shared package `invaders_pkg` holds:
  - the `msl_state_t` enum (IDLE, FLY, COOLDOWN);
  - screen constants H_ACTIVE = 640 and V_ACTIVE = 480;
  - the sprite size constants (player 30×20).
- One sub-module, `missile_seq`, contains the FSM, `fire_pend`/`hit_pend` capture, `cool_cnt`, and the `msl_*` registers.
- The movement/clamp logic stays in the top level.

## Test plan
- **Reset and right movement.** Reset, then hold `btn_right` for 3 frame ticks → `btn_col` reads 305, 309, 313, 317. `msl_active = 0`.
- **Left clamp.** Preload column 6, hold `btn_left` for 2 ticks → 2, then 0. A further tick stays at 0. Mirror case: 607 → 609 stays at 609.
- **Fire edge.** At column 305, give a fire edge mid-frame → after the next tick `msl_active = 1`, `msl_row = 430`, `msl_col = 320`. Next tick `msl_row = 422`. Holding fire causes no second launch.
- **Hit.** Pulse `hit` during FLY at `msl_row = 230` → at the next tick `msl_active = 0`. A fire pressed during the following 15 ticks is discarded. A press after those ticks launches.
- **Top exit.** Missile at `msl_row = 6` → at the next tick `msl_active = 0` with no row underflow.
- **Simultaneous events and reset.** Both buttons held → `btn_col` unchanged. `rst` asserted low mid-FLY → outputs show reset values on the same cycle.
